// File: rtl/data_memory_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package data_memory_unit_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   // An access is legal when its size is defined and it is naturally aligned.
   function automatic logic is_legal(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      ok = 1'b0;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~offset[0];
         SZ_WORD: ok = (offset == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_memory_unit_dmem_bank.sv
// Word-organised storage with byte-lane write enables and a registered read port.
module dmem_bank #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [3:0]            we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // No reset: contents survive system reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: aligned byte/half/word loads and stores with sign/zero extension.
module data_memory_unit #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_req,
   input  logic        in_we,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic [31:0] out_rdata,
   output logic        out_valid,
   output logic        out_err
);

   import data_memory_unit_pkg::*;

   logic [1:0]            offset;
   logic                  legal;
   logic                  wr_en;
   logic                  rd_en;
   logic [3:0]            lane_en;
   logic [31:0]           wdata_rep;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           bank_rdata;

   logic       valid_q;
   logic       err_q;
   logic       loaded_q;
   logic [1:0] offset_q;
   logic [1:0] size_q;
   logic       unsigned_q;

   logic [31:0] shifted;
   logic [31:0] load_word;

   // Address bits above the array size alias; they are intentionally dropped.
   logic unused_addr;
   assign unused_addr = ^in_addr[31:ADDR_WIDTH+2];

   assign offset   = in_addr[1:0];
   assign word_idx = in_addr[ADDR_WIDTH+1:2];
   assign legal    = is_legal(in_size, offset);
   // A store sampled while reset is high must not reach the array.
   assign wr_en    = in_req & in_we & legal & ~in_rst;
   assign rd_en    = in_req & ~in_we & legal & ~in_rst;

   always_comb begin
      lane_en   = 4'b0000;
      wdata_rep = in_wdata;
      case (in_size)
         SZ_BYTE: begin
            lane_en   = 4'b0001 << offset;
            wdata_rep = {4{in_wdata[7:0]}};
         end
         SZ_HALF: begin
            lane_en   = offset[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{in_wdata[15:0]}};
         end
         SZ_WORD: lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
      if (!wr_en) begin
         lane_en = 4'b0000;
      end
   end

   dmem_bank #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bank (
      .clk  (in_clk),
      .we   (lane_en),
      .re   (rd_en),
      .addr (word_idx),
      .wdata(wdata_rep),
      .rdata(bank_rdata)
   );

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         loaded_q   <= 1'b0;
         offset_q   <= 2'b00;
         size_q     <= SZ_WORD;
         unsigned_q <= 1'b0;
      end else begin
         valid_q <= rd_en;
         err_q   <= in_req & ~legal;
         if (rd_en) begin
            loaded_q   <= 1'b1;
            offset_q   <= offset;
            size_q     <= in_size;
            unsigned_q <= in_unsigned;
         end
      end
   end

   // The bank's read register holds between loads, so the formatted result holds too.
   always_comb begin
      shifted   = bank_rdata >> {offset_q, 3'b000};
      load_word = bank_rdata;
      case (size_q)
         SZ_BYTE: load_word = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_word = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
         default: load_word = bank_rdata;
      endcase
   end

   // loaded_q masks the unreset array output until the first load after reset.
   assign out_rdata = loaded_q ? load_word : 32'h0000_0000;
   assign out_valid = valid_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit.
module tb_data_memory_unit;

   logic        in_clk;
   logic        in_rst;
   logic        in_req;
   logic        in_we;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [31:0] out_rdata;
   logic        out_valid;
   logic        out_err;

   int n_tests;
   int n_fail;

   data_memory_unit #(
      .ADDR_WIDTH(10)
   ) dut (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .in_req     (in_req),
      .in_we      (in_we),
      .in_size    (in_size),
      .in_unsigned(in_unsigned),
      .in_addr    (in_addr),
      .in_wdata   (in_wdata),
      .out_rdata  (out_rdata),
      .out_valid  (out_valid),
      .out_err    (out_err)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Present one request for one edge, then sample 1 time unit after that edge.
   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      in_req      = 1'b1;
      in_we       = we;
      in_size     = size;
      in_unsigned = uns;
      in_addr     = addr;
      in_wdata    = wdata;
      @(posedge in_clk);
      #1;
      in_req = 1'b0;
   endtask

   task automatic idle();
      in_req = 1'b0;
      @(posedge in_clk);
      #1;
   endtask

   task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
      access(1'b0, size, uns, addr, 32'h0);
      check_eq({tag, " data"}, out_rdata, exp);
      check_eq({tag, " valid"}, {31'b0, out_valid}, 32'd1);
      check_eq({tag, " err"}, {31'b0, out_err}, 32'd0);
   endtask

   task automatic err_chk(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] hold);
      access(we, size, 1'b0, addr, 32'hA5A5_A5A5);
      check_eq({tag, " err"}, {31'b0, out_err}, 32'd1);
      check_eq({tag, " valid"}, {31'b0, out_valid}, 32'd0);
      check_eq({tag, " hold"}, out_rdata, hold);
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      in_rst      = 1'b1;
      in_req      = 1'b0;
      in_we       = 1'b0;
      in_size     = 2'b10;
      in_unsigned = 1'b0;
      in_addr     = 32'h0;
      in_wdata    = 32'h0;
      #1;
      check_eq("rst rdata", out_rdata, 32'h0);
      check_eq("rst valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst err", {31'b0, out_err}, 32'd0);
      repeat (2) @(posedge in_clk);
      #1;
      in_rst = 1'b0;
      idle();

      // Word store then back-to-back load.
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
      check_eq("st valid", {31'b0, out_valid}, 32'd0);
      check_eq("st err", {31'b0, out_err}, 32'd0);
      load_chk("ld w10", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
      idle();
      check_eq("idle valid", {31'b0, out_valid}, 32'd0);
      check_eq("idle hold", out_rdata, 32'hDEAD_BEEF);

      // Asynchronous reset while a load result is showing.
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check_eq("pre-rst valid", {31'b0, out_valid}, 32'd1);
      in_rst = 1'b1;
      #1;
      check_eq("mid-rst rdata", out_rdata, 32'h0);
      check_eq("mid-rst valid", {31'b0, out_valid}, 32'd0);
      check_eq("mid-rst err", {31'b0, out_err}, 32'd0);
      @(posedge in_clk);
      #1;
      in_rst = 1'b0;
      idle();
      check_eq("post-rst rdata", out_rdata, 32'h0);
      load_chk("ld after rst", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

      // Byte store and sub-word loads with both extensions.
      access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
      load_chk("ld w after sb", 2'b10, 1'b0, 32'h10, 32'h80AD_BEEF);
      load_chk("lb 13 s", 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
      load_chk("lb 13 u", 2'b00, 1'b1, 32'h13, 32'h0000_0080);
      load_chk("lh 12 s", 2'b01, 1'b0, 32'h12, 32'hFFFF_80AD);
      load_chk("lh 12 u", 2'b01, 1'b1, 32'h12, 32'h0000_80AD);
      load_chk("lh 10 s", 2'b01, 1'b0, 32'h10, 32'hFFFF_BEEF);
      load_chk("lb 10 s", 2'b00, 1'b0, 32'h10, 32'hFFFF_FFEF);
      load_chk("lb 11 s", 2'b00, 1'b0, 32'h11, 32'hFFFF_FFBE);

      // Illegal requests: flagged, no write, output held.
      err_chk("sw 11", 1'b1, 2'b10, 32'h11, 32'hFFFF_FFBE);
      err_chk("lh 13", 1'b0, 2'b01, 32'h13, 32'hFFFF_FFBE);
      err_chk("size 11", 1'b0, 2'b11, 32'h10, 32'hFFFF_FFBE);
      err_chk("sh 11", 1'b1, 2'b01, 32'h11, 32'hFFFF_FFBE);
      idle();
      check_eq("err drop", {31'b0, out_err}, 32'd0);
      load_chk("ld w after err", 2'b10, 1'b0, 32'h10, 32'h80AD_BEEF);

      // Wrap-around aliasing at 4 KiB.
      access(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678);
      load_chk("alias 0", 2'b10, 1'b0, 32'h0, 32'h1234_5678);

      // Lane enables: only targeted lanes change.
      access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111);
      access(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB);
      access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_5566);
      load_chk("lanes", 2'b10, 1'b0, 32'h20, 32'h5566_AB11);

      // Store sampled while reset is high is dropped.
      in_rst = 1'b1;
      access(1'b1, 2'b10, 1'b0, 32'h20, 32'h2222_2222);
      in_rst = 1'b0;
      idle();
      load_chk("st in rst", 2'b10, 1'b0, 32'h20, 32'h5566_AB11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Byte-addressable data memory for the MEM stage of the MIPS datapath. It executes one load or store per cycle with byte, halfword or word size. Loads are aligned and sign- or zero-extended here, so the returned word feeds the writeback-select mux memory input unchanged. Stores use per-byte lane enables; misaligned or illegal accesses are suppressed and flagged.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_req  input  1  access request this cycle.
- in_we  input  1  1 = store, 0 = load; ignored when in_req = 0.
- in_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- in_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend; ignored for word and for stores.
- in_addr  input  32  byte address.
- in_wdata  input  32  store data, right-justified: byte in [7:0], halfword in [15:0].
- out_rdata  output  32  load result, aligned and extended; goes to the writeback mux memory input.
- out_valid  output  1  out_rdata holds a new load result this cycle.
- out_err  output  1  one-cycle pulse: the previous request was misaligned or illegal.

## Operation
- Little-endian. Byte at in_addr[1:0] = k occupies word bits [8k+7:8k]. Halfword at offset 0 uses [15:0]; at offset 2 it uses [31:16].
- Word index = in_addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH bytes.
- Legality rules:
  - Byte: always legal.
  - Halfword: requires in_addr[0] = 0.
  - Word: requires in_addr[1:0] = 00.
  - in_size = 11 is always illegal.
- Legal store: in the request cycle, write the addressed lanes with replicated in_wdata (byte copied to all lanes, halfword to both halves). Lane enables select only the target lanes. Other lanes are unchanged. out_valid stays 0.
- Legal load: read the addressed word. Extract the target byte or halfword and extend it per in_unsigned. Register the result into out_rdata and assert out_valid for exactly one cycle.
- Illegal request, load or store: no memory write. out_err = 1 the next cycle. out_valid stays 0. out_rdata holds its previous value.
- No request: out_valid = 0, out_err = 0, out_rdata holds.
- The memory array is not reset; its contents are undefined after power-up and retained across in_rst.

## Timing
- Reset values: out_rdata = 0, out_valid = 0, out_err = 0. All take effect immediately on in_rst assertion, without waiting for a clock edge.
- Load latency is 1 cycle. A request sampled at edge N produces out_rdata/out_valid after edge N, valid until edge N+1.
- Store latency: the write commits at edge N. A load sampled at edge N+1 returns the new data. Back-to-back store then load to the same address needs no stall.
- Only one request per cycle, so there is no same-cycle read/write conflict.
- A request may be issued every cycle, and out_valid may stay high on consecutive cycles.
- Reset mid-operation: if in_rst is asserted in the cycle a load result would appear, out_valid is forced to 0. A store sampled at an edge where in_rst is already high is dropped.
- out_err and out_valid are never both 1.

## Structure
- Shared package holds the size encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILLEGAL = 2'b11.
- One sub-module, dmem_bank: the 2^ADDR_WIDTH × 32 storage with a 4-bit byte-lane write enable and a synchronous read. It has no reset.
- The top level handles:
  - legality check;
  - lane-enable and write-data replication;
  - load extraction and extension;
  - output registers.

## Test plan
- Assert in_rst mid-run → out_rdata = 0, out_valid = 0 and out_err = 0 immediately. Pre-written word at 0x10 still reads 0xDEADBEEF afterwards.
- Store word 0xDEADBEEF at 0x10, next cycle load word 0x10 → one cycle later out_rdata = 0xDEADBEEF, out_valid = 1 for one cycle.
- Store byte 0x80 at 0x13, then load word 0x10 → 0x80ADBEEF. Load byte 0x13 signed → 0xFFFFFF80. Unsigned → 0x00000080.
- Load halfword 0x12 signed → 0xFFFF80AD. Unsigned → 0x000080AD. Load halfword 0x10 → 0xFFFFBEEF.
- Store word at 0x11, then load halfword 0x13, then a request with size 11 → out_err pulses after each, out_valid = 0. Word at 0x10 still reads 0x80ADBEEF.
- With ADDR_WIDTH = 10, store word 0x12345678 at 0x1000, then load word 0x0 → 0x12345678 (wrap-around aliasing).
